// File: rtl/ram_rw_pkg.sv
// Shared types and helpers for the ram_rw_io memory responder.
// Holds the responder FSM encoding and the address-window decode.
package ram_rw_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } ram_rw_state_e;

   localparam int unsigned RAM_RW_DEF_DATA_WIDTH = 32;
   localparam int unsigned RAM_RW_DEF_ADDR_LSB   = $clog2(RAM_RW_DEF_DATA_WIDTH / 8);

   // One extra bit of headroom so base + size cannot wrap at the top of the address space.
   function automatic logic addr_in_window(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input int unsigned depth,
                                           input int unsigned bytes);
      logic [64:0] a;
      logic [64:0] lo;
      logic [64:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + (65'(depth) * 65'(bytes));
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/ram_rw_io.sv
// Single-master request/response bus between a core port and a memory endpoint.
interface ram_rw_io #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH/8-1:0] we;
   logic                    stb;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   wdata;
   logic                    ack;
   logic                    err;
   logic [DATA_WIDTH-1:0]   rdata;

   modport MASTER (output we, stb, addr, wdata, input ack, err, rdata);
   modport SLAVE  (input we, stb, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/ram_rw_mem_array.sv
// Single-port byte-write-enabled storage array with combinational read.
// Contents are never reset.
module ram_rw_mem_array #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 1024,
   parameter string       INIT_FILE  = ""
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [DATA_WIDTH/8-1:0]    be,
   input  logic [$clog2(DEPTH)-1:0]   idx,
   input  logic [DATA_WIDTH-1:0]      wdata,
   output logic [DATA_WIDTH-1:0]      rdata
);
   localparam int unsigned BYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < BYTES; i++) begin
            if (be[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/ram_rw_responder.sv
// Memory-side endpoint of ram_rw_io: decodes the window, inserts wait states,
// answers with a registered single-cycle ack (with rdata) or err.
module ram_rw_responder
   import ram_rw_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           DEPTH       = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned           WAIT_STATES = 0,
   parameter string                 INIT_FILE   = ""
) (
   input  logic   clk_i,
   input  logic   rst_i,
   ram_rw_io.SLAVE bus
);
   localparam int unsigned BYTES    = DATA_WIDTH / 8;
   localparam int unsigned ADDR_LSB = $clog2(BYTES);
   localparam int unsigned IDX_W    = $clog2(DEPTH);
   localparam int unsigned CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

   ram_rw_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [BYTES-1:0]      we_p0;
   logic [ADDR_WIDTH-1:0] addr_p0;
   logic [DATA_WIDTH-1:0] wdata_p0;

   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  capture, respond;
   logic [BYTES-1:0]      req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_bad;
   logic [IDX_W-1:0]      mem_idx;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_wr;

   // In IDLE the live bus is the request (zero-wait path); afterwards the captured copy is.
   always_comb begin
      req_we   = (state_q == IDLE) ? bus.we   : we_p0;
      req_addr = (state_q == IDLE) ? bus.addr : addr_p0;
      req_bad  = !addr_in_window(64'(req_addr), 64'(BASE_ADDR), DEPTH, BYTES)
                 || (|(req_addr & ALIGN_MASK));
   end

   assign mem_idx = req_addr[ADDR_LSB +: IDX_W];
   assign mem_wr  = (state_q == RESP) && ack_q && (|we_p0) && !rst_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      respond = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rdata_d = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.stb) begin
               capture = 1'b1;
               cnt_d   = '0;
               if (WAIT_STATES == 0) begin
                  state_d = RESP;
                  respond = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = RESP;
               respond = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (respond) begin
         err_d   = req_bad;
         ack_d   = !req_bad;
         rdata_d = (!req_bad && (req_we == '0)) ? mem_rdata : '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Request capture stage (p0): held for the whole transaction.
   always_ff @(posedge clk_i) begin
      if (capture) begin
         we_p0    <= bus.we;
         addr_p0  <= bus.addr;
         wdata_p0 <= bus.wdata;
      end
   end

   ram_rw_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .INIT_FILE  (INIT_FILE)
   ) u_mem (
      .clk   (clk_i),
      .wr_en (mem_wr),
      .be    (we_p0),
      .idx   (mem_idx),
      .wdata (wdata_p0),
      .rdata (mem_rdata)
   );

   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;

   a_ack_err_excl: assert property (@(posedge clk_i) disable iff (rst_i) !(ack_q && err_q));
   a_stb_held:     assert property (@(posedge clk_i) disable iff (rst_i) (state_q == WAIT) |-> bus.stb);

endmodule

// File: tb/tb_ram_rw_responder.sv
// Directed bench for ram_rw_responder with zero and three wait states, scoreboard-checked.
module tb_ram_rw_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ram_rw_io #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
   ram_rw_io #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

   ram_rw_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
      .clk_i (clk), .rst_i (rst), .bus (bus0));
   ram_rw_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
      .clk_i (clk), .rst_i (rst), .bus (bus3));

   typedef struct {
      logic        ack;
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   logic        sel;
   logic        ack_s, err_s;
   logic [31:0] rdata_s;
   assign ack_s   = sel ? bus3.ack   : bus0.ack;
   assign err_s   = sel ? bus3.err   : bus0.err;
   assign rdata_s = sel ? bus3.rdata : bus0.rdata;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
   endtask

   task automatic drive(input logic s, input logic stb, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (s) begin
         bus3.stb = stb; bus3.we = we; bus3.addr = addr; bus3.wdata = wdata;
      end else begin
         bus0.stb = stb; bus0.we = we; bus0.addr = addr; bus0.wdata = wdata;
      end
   endtask

   task automatic xact(input string tag, input logic s, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic eack, input logic eerr, input logic [31:0] erd, input int elat);
      exp_t e;
      int   n;
      bit   seen;
      sel = s;
      e.ack = eack; e.err = eerr; e.rdata = erd; e.lat = elat;
      sb.push_back(e);
      drive(s, 1'b1, we, addr, wdata);
      n = 0; seen = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (ack_s || err_s) seen = 1;
         else check({tag, "/rdata_idle"}, rdata_s, 32'h0);
      end
      e = sb.pop_front();
      check({tag, "/latency"}, 32'(n), 32'(e.lat));
      check({tag, "/ack"}, {31'h0, ack_s}, {31'h0, e.ack});
      check({tag, "/err"}, {31'h0, err_s}, {31'h0, e.err});
      check({tag, "/rdata"}, rdata_s, e.rdata);
      drive(s, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check({tag, "/pulse"}, {30'h0, ack_s, err_s}, 32'h0);
   endtask

   initial begin
      exp_t e;
      int   n;
      int   hits;

      rst = 1'b1;
      sel = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

      // Power-on reset: all outputs quiet.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("por/dut0", {bus0.ack, bus0.err, 30'h0} | bus0.rdata, 32'h0);
         check("por/dut3", {bus3.ack, bus3.err, 30'h0} | bus3.rdata, 32'h0);
      end
      rst = 1'b0;
      @(negedge clk);

      xact("wr20", 1'b0, 4'hF, 32'h20, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 1);

      // Reset held with a write request presented: no response, no write.
      drive(1'b0, 1'b1, 4'hF, 32'h20, 32'hFFFFFFFF);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_stb/out", {bus0.ack, bus0.err, 30'h0} | bus0.rdata, 32'h0);
      end
      rst = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      xact("rd20_after_rst", 1'b0, 4'h0, 32'h20, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, 1);

      xact("wr10", 1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1);
      xact("rd10", 1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1);
      xact("wr10_be5", 1'b0, 4'b0101, 32'h10, 32'h11223344, 1'b1, 1'b0, 32'h0, 1);
      xact("rd10_be5", 1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDE22BE44, 1);
      xact("wr10_bea", 1'b0, 4'b1010, 32'h10, 32'h99887766, 1'b1, 1'b0, 32'h0, 1);
      xact("rd10_bea", 1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h99227744, 1);

      xact("wr00", 1'b0, 4'hF, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 1);
      xact("rd1000_err", 1'b0, 4'h0, 32'h1000, 32'h0, 1'b0, 1'b1, 32'h0, 1);
      xact("wr1000_err", 1'b0, 4'hF, 32'h1000, 32'h0, 1'b0, 1'b1, 32'h0, 1);
      xact("wr02_err", 1'b0, 4'hF, 32'h2, 32'h12345678, 1'b0, 1'b1, 32'h0, 1);
      xact("rd00_untouched", 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hA5A5A5A5, 1);
      xact("rdfffffffc_err", 1'b0, 4'h0, 32'hFFFFFFFC, 32'h0, 1'b0, 1'b1, 32'h0, 1);
      xact("wrffc", 1'b0, 4'hF, 32'hFFC, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h0, 1);
      xact("rdffc", 1'b0, 4'h0, 32'hFFC, 32'h0, 1'b1, 1'b0, 32'h0F0F0F0F, 1);

      xact("ws3/wr40", 1'b1, 4'hF, 32'h40, 32'h01020304, 1'b1, 1'b0, 32'h0, 4);
      xact("ws3/rd40", 1'b1, 4'h0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h01020304, 4);

      // stb held high: second response arrives after one idle cycle plus the wait states.
      sel = 1'b1;
      e.ack = 1'b1; e.err = 1'b0; e.rdata = 32'h01020304; e.lat = 4; sb.push_back(e);
      e.lat = 9; sb.push_back(e);
      drive(1'b1, 1'b1, 4'h0, 32'h40, 32'h0);
      n = 0; hits = 0;
      while (hits < 2 && n < 30) begin
         @(negedge clk);
         n++;
         if ((ack_s || err_s) && sb.size() > 0) begin
            e = sb.pop_front();
            check("ws3/held/latency", 32'(n), 32'(e.lat));
            check("ws3/held/rdata", rdata_s, e.rdata);
            hits++;
         end
      end
      drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      check("ws3/held/count", 32'(hits), 32'd2);
      sb.delete();
      @(negedge clk);

      // Reset during the wait phase aborts a pending write.
      drive(1'b1, 1'b1, 4'hF, 32'h40, 32'hFFFFFFFF);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("ws3/abort/pre", {30'h0, ack_s, err_s}, 32'h0);
      end
      rst = 1'b1;
      drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("ws3/abort/rst", {ack_s, err_s, 30'h0} | rdata_s, 32'h0);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("ws3/abort/quiet", {30'h0, ack_s, err_s}, 32'h0);
      end
      xact("ws3/rd40_old", 1'b1, 4'h0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h01020304, 4);
      xact("ws3/rd1000_err", 1'b1, 4'h0, 32'h1000, 32'h0, 1'b0, 1'b1, 32'h0, 4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
